// File: rtl/osc_mixer_pkg.sv
// Shared audio definitions: gain format, mixer FSM states, saturation helper.
package osc_mixer_pkg;

    localparam int unsigned DEF_BITSIZE  = 24;
    localparam int unsigned DEF_GAINSIZE = 8;

    // Q1.(GAINSIZE-1) unity gain for the default gain width.
    localparam int unsigned GAIN_UNITY = 1 << (DEF_GAINSIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT
    } mix_state_t;

    typedef enum logic [1:0] {
        SAT_NONE,
        SAT_HI,
        SAT_LO
    } sat_kind_t;

    // Classifies a wide signed value against the signed range of 'bits' bits.
    // Callers clamp to the matching rail or keep the low 'bits' bits.
    function automatic sat_kind_t saturate(input logic signed [63:0] r,
                                           input int unsigned bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (r > hi)
            return SAT_HI;
        else if (r < lo)
            return SAT_LO;
        else
            return SAT_NONE;
    endfunction

endpackage

// File: rtl/osc_mixer_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a slow async strobe.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronise din into the clk domain and keep one delayed copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // One-cycle pulse on a synchronised rising edge.
    always_comb rise = s2 & ~s3;

endmodule

// File: rtl/osc_mixer.sv
// Four-channel time-multiplexed mixer with one shared multiplier.
module osc_mixer
    import osc_mixer_pkg::*;
#(
    parameter int unsigned BITSIZE  = 24,
    parameter int unsigned GAINSIZE = 8,
    parameter int unsigned SHIFT    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lrclk,
    input  logic signed [BITSIZE-1:0]  in_1,
    input  logic signed [BITSIZE-1:0]  in_2,
    input  logic signed [BITSIZE-1:0]  in_3,
    input  logic signed [BITSIZE-1:0]  in_4,
    input  logic        [GAINSIZE-1:0] gain_1,
    input  logic        [GAINSIZE-1:0] gain_2,
    input  logic        [GAINSIZE-1:0] gain_3,
    input  logic        [GAINSIZE-1:0] gain_4,
    input  logic        [3:0]          mute,
    output logic signed [BITSIZE-1:0]  out,
    output logic                       out_valid,
    output logic                       clip,
    output logic                       overrun
);

    localparam int unsigned PW  = BITSIZE + GAINSIZE + 1;
    localparam int unsigned AW  = BITSIZE + GAINSIZE + 3;
    localparam int unsigned RSH = GAINSIZE - 1 + SHIFT;

    mix_state_t state;
    mix_state_t state_next;

    logic                      start;
    logic signed [BITSIZE-1:0] samp [4];
    logic        [GAINSIZE-1:0] gn  [4];
    logic        [3:0]         mute_q;
    logic        [1:0]         ch;
    logic signed [AW-1:0]      acc;
    logic signed [PW-1:0]      samp_x;
    logic signed [PW-1:0]      gain_x;
    logic signed [PW-1:0]      prod;
    logic signed [AW-1:0]      r;
    sat_kind_t                 sat_kind;

    edge_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (lrclk),
        .rise (start)
    );

    // Shared multiplier on the current channel; muted channels contribute 0.
    always_comb begin
        samp_x = PW'(samp[ch]);
        gain_x = PW'({1'b0, gn[ch]});
        prod   = mute_q[ch] ? '0 : samp_x * gain_x;
    end

    // Master shift and range classification of the finished accumulation.
    always_comb begin
        r        = acc >>> RSH;
        sat_kind = saturate(64'(r), BITSIZE);
    end

    // Next-state logic: IDLE -> MAC (4 cycles) -> SAT (1 cycle) -> IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (ch == 2'd3) state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Snapshot, multiply-accumulate, saturate and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                samp[i] <= '0;
                gn[i]   <= '0;
            end
            mute_q    <= '0;
            ch        <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            clip      <= 1'b0;
            if (start && state != IDLE)
                overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        samp[0] <= in_1;
                        samp[1] <= in_2;
                        samp[2] <= in_3;
                        samp[3] <= in_4;
                        gn[0]   <= gain_1;
                        gn[1]   <= gain_2;
                        gn[2]   <= gain_3;
                        gn[3]   <= gain_4;
                        mute_q  <= mute;
                        acc     <= '0;
                        ch      <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + AW'(prod);
                    ch  <= ch + 2'd1;
                end
                SAT: begin
                    out_valid <= 1'b1;
                    unique case (sat_kind)
                        SAT_HI: begin
                            out  <= {1'b0, {(BITSIZE-1){1'b1}}};
                            clip <= 1'b1;
                        end
                        SAT_LO: begin
                            out  <= {1'b1, {(BITSIZE-1){1'b0}}};
                            clip <= 1'b1;
                        end
                        default: out <= r[BITSIZE-1:0];
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_osc_mixer.sv
// Directed bench for osc_mixer: two instances (SHIFT=0 and SHIFT=2) share stimulus.
module tb_osc_mixer;
    import osc_mixer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lrclk;
    logic [23:0] in_1, in_2, in_3, in_4;
    logic [7:0]  gain_1, gain_2, gain_3, gain_4;
    logic [3:0]  mute;
    logic [23:0] o0, o2;
    logic        v0, v2, c0, c2, ov0, ov2;

    int tests = 0;
    int fails = 0;

    osc_mixer #(.BITSIZE(24), .GAINSIZE(8), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .lrclk(lrclk),
        .in_1(in_1), .in_2(in_2), .in_3(in_3), .in_4(in_4),
        .gain_1(gain_1), .gain_2(gain_2), .gain_3(gain_3), .gain_4(gain_4),
        .mute(mute), .out(o0), .out_valid(v0), .clip(c0), .overrun(ov0)
    );

    osc_mixer #(.BITSIZE(24), .GAINSIZE(8), .SHIFT(2)) dut2 (
        .clk(clk), .rst(rst), .lrclk(lrclk),
        .in_1(in_1), .in_2(in_2), .in_3(in_3), .in_4(in_4),
        .gain_1(gain_1), .gain_2(gain_2), .gain_3(gain_3), .gain_4(gain_4),
        .mute(mute), .out(o2), .out_valid(v2), .clip(c2), .overrun(ov2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [23:0] a, b, c, d,
                          input logic [7:0] g1, g2, g3, g4, input logic [3:0] m);
        in_1 = a; in_2 = b; in_3 = c; in_4 = d;
        gain_1 = g1; gain_2 = g2; gain_3 = g3; gain_4 = g4;
        mute = m;
    endtask

    // One frame from an lrclk rise: snapshot on the 3rd posedge, result on the 8th.
    task automatic run_frame(input string tag,
                             input logic [23:0] a, b, c, d,
                             input logic [7:0] g1, g2, g3, g4, input logic [3:0] m,
                             input bit scramble,
                             input logic [23:0] e0, input logic c0e,
                             input logic [23:0] e2, input logic c2e);
        @(negedge clk);
        set_in(a, b, c, d, g1, g2, g3, g4, m);
        lrclk = 1'b1;
        repeat (3) @(negedge clk);
        if (scramble) set_in('0, '0, '0, '0, 8'd255, 8'd255, 8'd255, 8'd255, 4'b1010);
        repeat (4) @(negedge clk);
        chk({tag, "/early_v0"}, 32'(v0), 32'd0);
        chk({tag, "/early_v2"}, 32'(v2), 32'd0);
        @(negedge clk);
        chk({tag, "/v0"}, 32'(v0), 32'd1);
        chk({tag, "/out0"}, 32'(o0), 32'(e0));
        chk({tag, "/clip0"}, 32'(c0), 32'(c0e));
        chk({tag, "/v2"}, 32'(v2), 32'd1);
        chk({tag, "/out2"}, 32'(o2), 32'(e2));
        chk({tag, "/clip2"}, 32'(c2), 32'(c2e));
        @(negedge clk);
        chk({tag, "/post_v0"}, 32'(v0), 32'd0);
        chk({tag, "/post_clip0"}, 32'(c0), 32'd0);
        chk({tag, "/post_v2"}, 32'(v2), 32'd0);
        chk({tag, "/post_clip2"}, 32'(c2), 32'd0);
        lrclk = 1'b0;
        set_in(24'h123456, 24'h654321, 24'h0F0F0F, 24'hF0F0F0, 8'd7, 8'd9, 8'd11, 8'd13, 4'b0000);
        repeat (6) @(negedge clk);
        chk({tag, "/hold0"}, 32'(o0), 32'(e0));
        chk({tag, "/hold2"}, 32'(o2), 32'(e2));
    endtask

    initial begin
        int nv;
        logic [23:0] cap;
        rst   = 1'b1;
        lrclk = 1'b0;
        set_in('0, '0, '0, '0, '0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst/out0", 32'(o0), 32'd0);
        chk("rst/v0", 32'(v0), 32'd0);
        chk("rst/clip0", 32'(c0), 32'd0);
        chk("rst/ovr0", 32'(ov0), 32'd0);
        chk("rst/out2", 32'(o2), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("unity", 24'd1000, 24'd2000, -24'sd500, 24'd0,
                  GAIN_UNITY[7:0], GAIN_UNITY[7:0], GAIN_UNITY[7:0], GAIN_UNITY[7:0], 4'b0000, 1'b0,
                  24'd2500, 1'b0, 24'd625, 1'b0);
        run_frame("headroom", 24'h400000, 24'h400000, 24'h400000, 24'h400000,
                  8'd128, 8'd128, 8'd128, 8'd128, 4'b0000, 1'b0,
                  24'h7FFFFF, 1'b1, 24'h400000, 1'b0);
        run_frame("pos_sat", 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
                  8'd255, 8'd255, 8'd255, 8'd255, 4'b0000, 1'b0,
                  24'h7FFFFF, 1'b1, 24'h7FFFFF, 1'b1);
        run_frame("neg_sat", 24'h800000, 24'h800000, 24'h800000, 24'h800000,
                  8'd255, 8'd255, 8'd255, 8'd255, 4'b0000, 1'b0,
                  24'h800000, 1'b1, 24'h800000, 1'b1);
        run_frame("mute_snap", 24'd100, 24'd200, 24'd300, 24'd400,
                  8'd128, 8'd128, 8'd128, 8'd128, 4'b0101, 1'b1,
                  24'd600, 1'b0, 24'd150, 1'b0);
        run_frame("gain_mix", 24'd1000, 24'd3, 24'd0, 24'd0,
                  8'd64, 8'd255, 8'd0, 8'd0, 4'b0000, 1'b0,
                  24'd505, 1'b0, 24'd126, 1'b0);
        run_frame("negative", 24'hFFFC18, 24'hFFFC18, 24'hFFFC18, 24'hFFFC18,
                  8'd128, 8'd128, 8'd128, 8'd128, 4'b0000, 1'b0,
                  24'hFFF060, 1'b0, 24'hFFFC18, 1'b0);
        run_frame("max_edge", 24'h7FFFFF, 24'd0, 24'd0, 24'd0,
                  8'd128, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b0,
                  24'h7FFFFF, 1'b0, 24'h1FFFFF, 1'b0);
        run_frame("min_edge", 24'h800000, 24'd0, 24'd0, 24'd0,
                  8'd128, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b0,
                  24'h800000, 1'b0, 24'hE00000, 1'b0);

        // Overrun: a second lrclk rise lands while the first frame is in MAC.
        chk("ovr/before", 32'(ov0), 32'd0);
        @(negedge clk);
        set_in(24'd1000, 24'd2000, -24'sd500, 24'd0, 8'd128, 8'd128, 8'd128, 8'd128, 4'b0000);
        lrclk = 1'b1;
        repeat (3) @(negedge clk);
        lrclk = 1'b0;
        @(negedge clk);
        lrclk = 1'b1;
        nv  = 0;
        cap = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (v0) begin
                nv++;
                cap = o0;
            end
        end
        chk("ovr/valid_count", 32'(nv), 32'd1);
        chk("ovr/frame_out", 32'(cap), 32'd2500);
        chk("ovr/flag0", 32'(ov0), 32'd1);
        chk("ovr/flag2", 32'(ov2), 32'd1);
        lrclk = 1'b0;
        repeat (4) @(negedge clk);
        run_frame("after_ovr", 24'd10, 24'd20, 24'd30, 24'd40,
                  8'd128, 8'd128, 8'd128, 8'd128, 4'b0000, 1'b0,
                  24'd100, 1'b0, 24'd25, 1'b0);
        chk("ovr/sticky", 32'(ov0), 32'd1);

        // Reset during MAC cycle 2 aborts the frame.
        @(negedge clk);
        set_in(24'd5000, 24'd5000, 24'd5000, 24'd5000, 8'd128, 8'd128, 8'd128, 8'd128, 4'b0000);
        lrclk = 1'b1;
        repeat (5) @(negedge clk);
        rst   = 1'b1;
        lrclk = 1'b0;
        #1;
        chk("rstmid/out0", 32'(o0), 32'd0);
        chk("rstmid/ovr0", 32'(ov0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (v0 || v2) nv++;
        end
        chk("rstmid/no_valid", 32'(nv), 32'd0);
        chk("rstmid/out_hold", 32'(o0), 32'd0);
        run_frame("post_rst", 24'd1000, 24'd2000, -24'sd500, 24'd0,
                  8'd128, 8'd128, 8'd128, 8'd128, 4'b0000, 1'b0,
                  24'd2500, 1'b0, 24'd625, 1'b0);
        chk("post_rst/ovr0", 32'(ov0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/osc_mixer.md
Name: osc_mixer

Overview:
- Four-channel time-multiplexed mixer that sits directly downstream of the four-voice waveform generator.
- Once per audio frame it snapshots the four signed voice samples and multiplies each by its per-channel gain using one shared multiplier.
- It accumulates the four products, applies a master shift, saturates, and presents one signed sample to the I2S transmitter with a one-cycle valid strobe.

Parameters:
- BITSIZE, 24, width of input voice samples and of the mixed output (two's complement).
- GAINSIZE, 8, width of each unsigned gain; format Q1.(GAINSIZE-1), so 2^(GAINSIZE-1) = unity (128 = 1.0, 255 = 1.99).
- SHIFT, 2, master arithmetic right shift applied after accumulation, for headroom.

Ports:
- clk  in  1  system clock; lrclk is much slower than clk.
- rst  in  1  reset, asynchronous, active-high.
- lrclk  in  1  I2S word clock; asynchronous to clk; a rising edge starts one mix frame.
- in_1..in_4  in  BITSIZE each  signed voice samples from the generator.
- gain_1..gain_4  in  GAINSIZE each  unsigned per-channel gains.
- mute  in  4  bit i-1 set forces channel i's contribution to 0.
- out  out  BITSIZE  signed mixed sample; holds its value between frames.
- out_valid  out  1  one-cycle pulse when out updates.
- clip  out  1  high together with out_valid when the frame saturated; 0 otherwise.
- overrun  out  1  sticky; set when a frame start arrives while busy; cleared only by rst.

Behaviour:
- Reset (async, any state): out=0, out_valid=0, clip=0, overrun=0, accumulator=0, channel counter=0, FSM=IDLE, synchroniser flops=0.
- Frame-start detection:
  - lrclk passes through two synchroniser flops s1 and s2, then a delay flop s3.
  - start = s2 & ~s3.
  - A rising lrclk edge produces exactly one start pulse, 2-3 clk after the edge.
- FSM states are IDLE, MAC and SAT.
- IDLE:
  - On start, snapshot in_1..in_4, gain_1..gain_4 and mute into internal registers.
  - Clear the accumulator, set ch=0, go to MAC.
  - Inputs may change freely after the snapshot edge.
- MAC (exactly 4 cycles, ch = 0..3):
  - acc <= acc + (mute[ch] ? 0 : sample[ch] * $signed({1'b0, gain[ch]})).
  - Product is signed, BITSIZE+GAINSIZE+1 bits. Accumulator is BITSIZE+GAINSIZE+3 bits, so it can never wrap.
  - After ch=3, go to SAT.
- SAT (1 cycle):
  - r = acc >>> (GAINSIZE-1+SHIFT), arithmetic shift, truncation toward negative infinity.
  - If r > 2^(BITSIZE-1)-1: out = max positive, clip=1.
  - If r < -2^(BITSIZE-1): out = min negative, clip=1.
  - Otherwise out = r[BITSIZE-1:0], clip=0.
  - out_valid=1; return to IDLE.
- out_valid and clip return to 0 on the next edge.
- Latency: with the snapshot edge as edge 0, out and out_valid update on edge 5 (4 MAC edges plus the SAT edge). Next start is accepted from edge 6 onward.
- A start while in MAC or SAT is ignored: the frame in flight completes unchanged and overrun is set to 1.
- A start on the same edge the FSM enters IDLE cannot occur, since SAT→IDLE precedes acceptance. A start seen in IDLE is always accepted.
- lrclk held constant produces no frames; out holds its last value indefinitely.
- rst asserted mid-frame aborts the frame: no out_valid is produced, and the next start after rst release runs a clean frame.

Decomposition:
- Shared audio package holds:
  - the gain unity constant (1 << (GAINSIZE-1));
  - the mixer FSM state enum {IDLE, MAC, SAT};
  - a saturate-to-BITSIZE function reused by the future effects chain.
- One natural sub-module: edge_sync, the two-flop synchroniser plus rising-edge detector on lrclk. It is reusable by any block that is framed on lrclk.
- The multiply-accumulate datapath stays inline.

Test Plan:
- Unity gain sum: in_1..4 = 1000, 2000, -500, 0; gains all 128; mute=0; SHIFT=0 → out=2500 on edge 5 after snapshot; out_valid pulses exactly 1 cycle; clip=0.
- Headroom shift: SHIFT=2, gains all 128, all inputs 0x400000 (4194304) → out = 16777216>>2 = 4194304; clip=0.
- Positive saturation: SHIFT=0, gains 255, all inputs 0x7FFFFF → out=0x7FFFFF, clip=1. Same with all inputs 0x800000 → out=0x800000, clip=1.
- Mute and snapshot: mute=4'b0101, inputs 100, 200, 300, 400, gains 128, SHIFT=0, and change all inputs to 0 one cycle after start → out=600.
- Overrun: pulse lrclk twice within 3 clk of the first detected start → exactly one out_valid; overrun=1 and stays 1 until rst.
- Reset mid-frame: assert rst during MAC cycle 2 → out=0 and no out_valid. After release, one lrclk rising edge → normal frame result.
